seq_adder_ctrl: RTL and testbench
=================================

Name: seq_adder_ctrl

Overview:
- Multi-cycle 32-bit add/subtract sequencer that time-shares one 8-bit carry-lookahead slice (CLA8) across four clock cycles.
- Chains the carry between slices using the slice's group generate/propagate outputs.
- Exposes a start/ready handshake to the ALU so a wide adder is not needed in area-constrained builds.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 8.
- SLICES, WIDTH/8, number of slice passes per operation (derived; not overridden).

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ctrl_start  input  1  request a new operation; sampled only when not busy.
- ctrl_sub  input  1  1 = A − B, 0 = A + B; latched with start.
- data_operandA  input  WIDTH  operand A; latched with start.
- data_operandB  input  WIDTH  operand B; latched with start.
- data_result  output  WIDTH  sum/difference; stable from resultRDY until the next completion.
- data_carryOut  output  1  carry out of MSB (for sub: 1 = no borrow).
- data_overflow  output  1  signed two's-complement overflow.
- data_resultRDY  output  1  one-cycle pulse when the result is valid.
- busy  output  1  high while an operation is in progress.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - State goes to IDLE; slice index = 0; carry register = 0; operand registers = 0.
  - data_result = 0, data_carryOut = 0, data_overflow = 0, data_resultRDY = 0, busy = 0.
  - No partial result is retained.
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy = 0. On an edge with ctrl_start = 1, latch A, (ctrl_sub ? ~B : B) and ctrl_sub. Set carry register = ctrl_sub, index = 0, go to RUN.
  - RUN: busy = 1. Each cycle, slice index i drives CLA8 with A[8i+7:8i], B'[8i+7:8i] and C0 = carry register.
    - At the edge: write S into working-result byte i; carry register <= G | (P & carry register); i <= i+1.
    - After the pass with i = SLICES−1, go to DONE.
  - DONE: busy = 0, data_resultRDY = 1 for exactly this cycle. data_result, data_carryOut and data_overflow are all updated at the edge entering DONE.
    - Next edge: start = 1 is accepted (back-to-back, same as IDLE → RUN); otherwise go to IDLE.
- Latency: start sampled at edge E0. RUN passes commit at E1..E4. data_resultRDY is high between E4 and E5. Throughput is one op per 5 cycles.
- ctrl_start while in RUN is ignored: no queueing and no error flag. Operand changes after E0 have no effect.
- Overflow = (A[MSB] == B'[MSB]) & (result[MSB] != A[MSB]), using latched A, B'.
- data_carryOut = final carry register value (carry out of slice SLICES−1).
- Output registers hold their last values through IDLE and RUN; they change only at DONE entry or reset.
- Carry chaining relies on CLA8 P being the AND of bitwise ORs. G | (P & c) is exact for generate/propagate of the OR form; no internal carry-7 is needed.

Decomposition:
- Shared package: FSM state encoding (IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10), SLICE_W = 8 constant, and an index-width helper.
- Sub-module: one CLA8 instance, existing, unmodified. Byte-select muxes and the carry register stay in seq_adder_ctrl.

Test Plan:
- Add 0x00FF00FF + 0x00010001 → 0x01000100, carryOut = 0, overflow = 0. resultRDY exactly 4 cycles after the start edge (high between E4 and E5). Checks slice-to-slice carry.
- Add 0x7FFFFFFF + 0x00000001 → 0x80000000, overflow = 1, carryOut = 0. Add 0xFFFFFFFF + 0x00000001 → 0x00000000, carryOut = 1, overflow = 0.
- Sub 5 − 7 → 0xFFFFFFFE, carryOut = 0, overflow = 0. Sub 0x80000000 − 1 → 0x7FFFFFFF, overflow = 1, carryOut = 1.
- Start 0x10 + 0x20, then pulse start with 0x1 + 0x1 during RUN → only 0x00000030 is produced. A start held high in the DONE cycle launches a second op with no IDLE cycle between.
- Assert reset asynchronously between E2 and E3 of an op → all outputs 0 immediately, busy = 0. A new op after release (0x3 + 0x4) → 0x00000007 with normal latency.
- Random 1000 ops with mixed add/sub compared against a reference model: result, carryOut, overflow and the one-cycle resultRDY pulse all match.

Source files
------------

// File: rtl/seq_adder_ctrl_pkg.sv
// seq_adder_ctrl_pkg: shared FSM encoding, slice width and index sizing helper.
package seq_adder_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
  localparam int SLICE_W = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seq_adder_ctrl_cla8.sv
// cla8: 8-bit carry-lookahead slice with OR-form group generate/propagate.
module cla8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] s_o,
  output logic       g_o,
  output logic       p_o
);
  logic [7:0] g, p, c;
  always_comb begin
    g = a_i & b_i;
    p = a_i | b_i;
    c = '0;
    c[0] = c_i;
    for (int k = 0; k < 7; k++) c[k+1] = g[k] | (p[k] & c[k]);
    s_o = a_i ^ b_i ^ c;
    g_o = 1'b0;
    for (int k = 0; k < 8; k++) g_o = g[k] | (p[k] & g_o);
    p_o = &p;
  end
endmodule

// File: rtl/seq_adder_ctrl.sv
// seq_adder_ctrl: 32-bit add/sub sequenced over one shared CLA8 slice, one byte per cycle.
module seq_adder_ctrl
  import seq_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic             ctrl_sub,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_carryOut,
  output logic             data_overflow,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int SLICES = WIDTH / SLICE_W;
  localparam int IW = idx_w(SLICES);
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);
  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, w_q, w_d, res_q, res_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [7:0]       sl_a, sl_b, sl_s;
  logic             sl_g, sl_p, launch, last, run;
  assign sl_a = a_q[SLICE_W*idx_q +: SLICE_W];
  assign sl_b = b_q[SLICE_W*idx_q +: SLICE_W];
  cla8 u_cla (
    .a_i(sl_a),
    .b_i(sl_b),
    .c_i(carry_q),
    .s_o(sl_s),
    .g_o(sl_g),
    .p_o(sl_p)
  );
  always_comb begin
    run     = state_q == RUN;
    last    = idx_q == LAST;
    launch  = !run && ctrl_start;
    state_d = launch ? RUN : run ? (last ? DONE : RUN) : IDLE;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (run) begin
      w_d[SLICE_W*idx_q +: SLICE_W] = sl_s;
      carry_d = sl_g | (sl_p & carry_q);
      idx_d   = last ? '0 : idx_q + IW'(1);
      if (last) begin
        res_d  = w_d;
        cout_d = carry_d;
        ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_d[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
    if (launch) begin
      a_d     = data_operandA;
      b_d     = ctrl_sub ? ~data_operandB : data_operandB;
      carry_d = ctrl_sub;
      idx_d   = '0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign data_result    = res_q;
  assign data_carryOut  = cout_q;
  assign data_overflow  = ovf_q;
  assign data_resultRDY = state_q == DONE;
  assign busy           = state_q == RUN;
endmodule

// File: tb/tb_seq_adder_ctrl.sv
// tb_seq_adder_ctrl: directed vector table, multi-cycle corner sequences and a random model check.
module tb_seq_adder_ctrl;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, sub = 1'b0;
  logic [31:0] opa = '0, opb = '0, result;
  logic        cout, ovf, rdy, busy;
  int          checks = 0, errors = 0;

  typedef struct {
    logic        sub;
    logic [31:0] a, b, r;
    logic        c, v;
  } vec_t;
  vec_t tv[7];

  always #5 clock = ~clock;

  seq_adder_ctrl dut (
    .clock(clock), .reset(reset), .ctrl_start(start), .ctrl_sub(sub),
    .data_operandA(opa), .data_operandB(opb), .data_result(result),
    .data_carryOut(cout), .data_overflow(ovf), .data_resultRDY(rdy), .busy(busy)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask

  // Returns edges after the start edge at which rdy was seen (sampled on negedges).
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!rdy && lat < 20) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1; sub = s; opa = a; opb = b;
    @(negedge clock);
    start = 1'b0; sub = ~s; opa = $urandom; opb = $urandom;
  endtask

  task automatic do_op(input string n, input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ec, input logic ev);
    int lat;
    launch(s, a, b);
    chk({n, "_busy"}, 32'(busy), 32'd1);
    wait_rdy(lat);
    chk({n, "_lat"}, 32'(lat), 32'd4);
    chk({n, "_res"}, result, er);
    chk({n, "_flags"}, {30'd0, cout, ovf}, {30'd0, ec, ev});
    @(negedge clock);
    chk({n, "_pulse"}, {30'd0, rdy, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] ra, rb, rr;
    logic [32:0] full;
    logic rs, rv;
    tv[0] = '{1'b0, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0};
    tv[1] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    tv[2] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    tv[3] = '{1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0};
    tv[4] = '{1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1};
    tv[5] = '{1'b1, 32'h00000007, 32'h00000005, 32'h00000002, 1'b1, 1'b0};
    tv[6] = '{1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0};
    repeat (2) @(negedge clock);
    chk("reset_out", result, 32'd0);
    chk("reset_ctl", {28'd0, cout, ovf, rdy, busy}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) do_op($sformatf("vec%0d", i), tv[i].sub, tv[i].a, tv[i].b, tv[i].r, tv[i].c, tv[i].v);

    // Start pulse during RUN must be ignored.
    launch(1'b0, 32'h10, 32'h20);
    @(negedge clock);
    start = 1'b1; opa = 32'h1; opb = 32'h1;
    @(negedge clock);
    start = 1'b0;
    wait_rdy(lat);
    chk("ign_res", result, 32'h30);
    rv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      rv |= rdy | busy;
    end
    chk("ign_nosecond", 32'(rv), 32'd0);

    // Back-to-back: start held in the DONE cycle.
    launch(1'b0, 32'h3, 32'h4);
    wait_rdy(lat);
    chk("b2b_first", result, 32'h7);
    start = 1'b1; opa = 32'h100; opb = 32'h200; sub = 1'b0;
    @(negedge clock);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_hold", result, 32'h7);
    wait_rdy(lat);
    chk("b2b_lat", 32'(lat), 32'd4);
    chk("b2b_res", result, 32'h300);

    // Asynchronous reset between E2 and E3.
    launch(1'b0, 32'h12345678, 32'h1);
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_res", result, 32'd0);
    chk("arst_ctl", {28'd0, cout, ovf, rdy, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    do_op("post_rst", 1'b0, 32'h3, 32'h4, 32'h7, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      if (i % 7 == 0) rb = ra;
      full = rs ? {1'b0, ra} + {1'b0, ~rb} + 33'd1 : {1'b0, ra} + {1'b0, rb};
      rr = full[31:0];
      rv = rs ? (ra[31] != rb[31]) && (rr[31] != ra[31]) : (ra[31] == rb[31]) && (rr[31] != ra[31]);
      do_op($sformatf("rnd%0d", i), rs, ra, rb, rr, full[32], rv);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
